// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting one of N_REQ requesters write access to a shared WIDTH-bit register.
// Latency: Req sampled at edge k gives Gnt after edge k; the first capture into Q is at edge k+1.
// Backpressure: a requester keeps ownership while it holds Req, for at most MAX_HOLD capture edges.
//
// Ports:
//   Clk   - rising-edge clock
//   Rst_n - asynchronous active-low reset
//   Req   - level-sensitive request, one bit per requester
//   D     - packed data, requester i at [i*WIDTH +: WIDTH]
//   Gnt   - registered one-hot grant
//   Q     - shared register contents
//   notQ  - bitwise complement of Q
//   Busy  - high while any grant is active
module dff_bank_arbiter #(
    parameter int WIDTH    = 8,
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] D,
    output logic [N_REQ-1:0]       Gnt,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       notQ,
    output logic                   Busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;     // first requester considered at the next arbitration
    logic [PTR_W-1:0]   gnt_idx;    // binary index of the current owner
    logic [CNT_W-1:0]   hold_cnt;   // captures made in the current grant

    logic [PTR_W-1:0]   nxt_ptr;
    logic [PTR_W-1:0]   arb_start;
    logic [PTR_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_onehot;
    logic [WIDTH-1:0]   own_dat;
    logic [CNT_W-1:0]   cnt_inc;
    logic               own_req;
    logic               hold_done;
    logic               release_grant;

    // First set bit of req searching upward from start, wrapping modulo N_REQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(start) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
        return pick;
    endfunction

    always_comb begin
        nxt_ptr = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        // A release re-arbitrates from the advanced pointer in the same edge,
        // so the search origin already reflects the pointer update.
        arb_start     = (state == GRANT) ? nxt_ptr : rr_ptr;
        pick_idx      = rr_pick(Req, arb_start);
        pick_onehot   = N_REQ'(1) << pick_idx;
        own_dat       = D[int'(gnt_idx) * WIDTH +: WIDTH];
        own_req       = Req[gnt_idx];
        cnt_inc       = hold_cnt + 1'b1;
        // A timeout only arises from a capture, so a dropped Req always wins
        // and no capture happens on that edge.
        hold_done     = own_req && (cnt_inc == CNT_W'(MAX_HOLD));
        release_grant = !own_req || hold_done;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            Gnt      <= '0;
            Q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|Req) begin
                        state    <= GRANT;
                        gnt_idx  <= pick_idx;
                        Gnt      <= pick_onehot;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (own_req) begin
                        Q <= own_dat;
                    end
                    if (release_grant) begin
                        rr_ptr   <= nxt_ptr;
                        hold_cnt <= '0;
                        if (|Req) begin
                            // Back-to-back handover; a lone requester at
                            // timeout is simply re-granted here.
                            gnt_idx <= pick_idx;
                            Gnt     <= pick_onehot;
                        end else begin
                            Gnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    Gnt   <= '0;
                end
            endcase
        end
    end

    assign notQ = ~Q;
    assign Busy = |Gnt;

endmodule
